// File: rtl/segway_seq_pkg.sv
// segway_seq_pkg
// Shared types and constants for the Segway power/steer sequencer.
//   seq_state_t   : sequencer states (also exported as a debug output)
//   SS_FULL       : full soft-start gain
//   *_DEF         : default parameter values for segway_seq_ctrl
//   SEQ_CNT_W     : width of the consecutive-sample counters
package segway_seq_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        FAULT = 3'd3,
        DOWN  = 3'd4
    } seq_state_t;

    localparam logic [7:0] SS_FULL      = 8'hFF;
    localparam logic [7:0] SS_STEP_DEF  = 8'd1;
    localparam int         TF_LIMIT_DEF = 4;
    localparam int         TF_CLR_DEF   = 16;
    localparam int         SEQ_CNT_W    = 5;

endpackage

// File: rtl/segway_seq_if.sv
// segway_seq_if
// Rider/authorization inputs and sequencer outputs of segway_seq_ctrl.
//   master : drives pwr_req, rider_on, steer_ok, vld, too_fast
//   slave  : the sequencer; drives pwr_up, ss_tmr, en_steer, fault, state
// Handshake: vld is a one-cycle-per-sample strobe with no back-pressure;
// too_fast is only meaningful in a cycle where vld=1. The level inputs
// pwr_req/rider_on/steer_ok are sampled on every clk edge.
interface segway_seq_if;
    import segway_seq_pkg::*;

    logic       pwr_req;
    logic       rider_on;
    logic       steer_ok;
    logic       vld;
    logic       too_fast;
    logic       pwr_up;
    logic [7:0] ss_tmr;
    logic       en_steer;
    logic       fault;
    seq_state_t state;      // debug view of the sequencer state register

    modport master (
        output pwr_req, rider_on, steer_ok, vld, too_fast,
        input  pwr_up, ss_tmr, en_steer, fault, state
    );

    modport slave (
        input  pwr_req, rider_on, steer_ok, vld, too_fast,
        output pwr_up, ss_tmr, en_steer, fault, state
    );

endinterface

// File: rtl/segway_seq_ctrl_run_cnt.sv
// seq_run_cnt
// Counts consecutive vld samples on which evt=1. A vld sample with evt=0
// restarts the count. hit pulses (combinationally) on the sample that
// brings the count to limit, and the counter restarts from zero there.
//   clk, rst_n : clock, async active-low reset
//   clr        : hold the counter at zero (owner state not active)
//   vld        : sample strobe
//   evt        : event qualifier for this sample
//   limit      : run length that produces hit (1..31)
//   hit        : run length reached on this sample
module seq_run_cnt
    import segway_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 vld,
    input  logic                 evt,
    input  logic [SEQ_CNT_W-1:0] limit,
    output logic                 hit
);

    logic [SEQ_CNT_W-1:0] cnt_q;
    logic [SEQ_CNT_W-1:0] cnt_d;
    logic [SEQ_CNT_W:0]   cnt_inc;

    // One extra bit so a limit of 31 compares without wrapping.
    assign cnt_inc = {1'b0, cnt_q} + {{SEQ_CNT_W{1'b0}}, 1'b1};
    assign hit     = !clr && vld && evt && (cnt_inc == {1'b0, limit});

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (vld) begin
            if (!evt || hit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc[SEQ_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/segway_seq_ctrl.sv
// segway_seq_ctrl
// Power and steering sequencer: powers the motor math, ramps the soft-start
// gain up/down one SS_STEP per vld, gates steering and trips a steering
// inhibit fault after TF_LIMIT consecutive overspeed samples.
//   clk, rst_n : clock, async active-low reset
//   bus        : segway_seq_if.slave (inputs pwr_req/rider_on/steer_ok/
//                vld/too_fast; registered outputs pwr_up/ss_tmr/en_steer/
//                fault plus debug state)
// Build option SEQ_FAULT_STICKY_EN: FAULT only exits through loss of go;
// the clean-sample counter is not built and TF_CLR is unused.
module segway_seq_ctrl
    import segway_seq_pkg::*;
#(
    parameter logic [7:0] SS_STEP  = SS_STEP_DEF,
    parameter int         TF_LIMIT = TF_LIMIT_DEF,
    parameter int         TF_CLR   = TF_CLR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    segway_seq_if.slave  bus
);

    seq_state_t state_q, state_d;
    logic [7:0] ss_q, ss_d;
    logic       pwr_up_q, pwr_up_d;
    logic       en_steer_q, en_steer_d;
    logic       fault_q, fault_d;

    logic       go;
    logic [8:0] ss_sum;
    logic [7:0] ss_up;
    logic [7:0] ss_dn;
    logic       tf_hit;
    logic       clean_hit;

    assign go     = bus.pwr_req & bus.rider_on;
    // 9-bit sum so a large step saturates at full gain instead of wrapping.
    assign ss_sum = {1'b0, ss_q} + {1'b0, SS_STEP};
    assign ss_up  = (ss_sum >= 9'd255) ? SS_FULL : ss_sum[7:0];
    assign ss_dn  = (ss_q <= SS_STEP) ? 8'd0 : (ss_q - SS_STEP);

    // Counters are held clear outside their owning state, so every entry
    // starts from zero.
    seq_run_cnt u_tf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != RUN),
        .vld   (bus.vld),
        .evt   (bus.too_fast),
        .limit (SEQ_CNT_W'(TF_LIMIT)),
        .hit   (tf_hit)
    );

`ifdef SEQ_FAULT_STICKY_EN
    assign clean_hit = 1'b0;
`else
    seq_run_cnt u_clean_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != FAULT),
        .vld   (bus.vld),
        .evt   (!bus.too_fast),
        .limit (SEQ_CNT_W'(TF_CLR)),
        .hit   (clean_hit)
    );
`endif

    always_comb begin
        state_d = state_q;
        ss_d    = ss_q;
        case (state_q)
            OFF: begin
                ss_d = 8'd0;
                if (go) state_d = RAMP;
            end
            RAMP: begin
                if (!go) begin
                    state_d = DOWN;
                end else if (bus.vld) begin
                    ss_d = ss_up;
                    if (ss_up == SS_FULL) state_d = RUN;
                end
            end
            RUN: begin
                ss_d = SS_FULL;
                if (!go)         state_d = DOWN;
                else if (tf_hit) state_d = FAULT;
            end
            FAULT: begin
                ss_d = SS_FULL;
                if (!go)            state_d = DOWN;
                else if (clean_hit) state_d = RUN;
            end
            DOWN: begin
                // Re-ramp resumes from the current gain, no jump.
                if (go) begin
                    state_d = RAMP;
                end else if (bus.vld) begin
                    ss_d = ss_dn;
                    if (ss_dn == 8'd0) state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
                ss_d    = 8'd0;
            end
        endcase

        // Outputs decode the next state so they change on the same edge
        // as the transition (en_steer drops on the edge leaving RUN).
        pwr_up_d   = (state_d != OFF);
        en_steer_d = (state_d == RUN) && bus.steer_ok;
        fault_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            ss_q       <= 8'd0;
            pwr_up_q   <= 1'b0;
            en_steer_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_q       <= ss_d;
            pwr_up_q   <= pwr_up_d;
            en_steer_q <= en_steer_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.ss_tmr   = ss_q;
    assign bus.pwr_up   = pwr_up_q;
    assign bus.en_steer = en_steer_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_segway_seq_ctrl.sv
// tb_segway_seq_ctrl
// Directed bench for segway_seq_ctrl: one instance with the default step
// and one with SS_STEP=100 for the saturation case. Expectations for the
// fault-exit case depend on SEQ_FAULT_STICKY_EN.
module tb_segway_seq_ctrl;
  import segway_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  segway_seq_if aif ();
  segway_seq_if bif ();

  segway_seq_ctrl u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (aif.slave)
  );

  segway_seq_ctrl #(.SS_STEP(8'd100)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vld_a(input int n);
    for (int i = 0; i < n; i++) begin
      aif.vld = 1'b1;
      tick();
    end
    aif.vld = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    aif.pwr_req = 1'b0; aif.rider_on = 1'b0; aif.steer_ok = 1'b0;
    aif.vld     = 1'b0; aif.too_fast = 1'b0;
    bif.pwr_req = 1'b0; bif.rider_on = 1'b0; bif.steer_ok = 1'b0;
    bif.vld     = 1'b0; bif.too_fast = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_pwr_up",   32'(aif.pwr_up),   32'd0);
    chk("rst_ss_tmr",   32'(aif.ss_tmr),   32'd0);
    chk("rst_en_steer", 32'(aif.en_steer), 32'd0);
    chk("rst_fault",    32'(aif.fault),    32'd0);
    chk("rst_state",    32'(aif.state),    32'(OFF));
    rst_n = 1'b1;
    tick();

    // SS_STEP=100: 100, 200, then saturate at 255 into RUN
    bif.pwr_req = 1'b1; bif.rider_on = 1'b1; bif.steer_ok = 1'b1;
    tick();
    chk("b_ramp_state", 32'(bif.state),  32'(RAMP));
    chk("b_ramp_pwr",   32'(bif.pwr_up), 32'd1);
    chk("b_ramp_ss0",   32'(bif.ss_tmr), 32'd0);
    bif.vld = 1'b1;
    tick();
    chk("b_ss_100", 32'(bif.ss_tmr), 32'd100);
    tick();
    chk("b_ss_200", 32'(bif.ss_tmr), 32'd200);
    chk("b_state_200", 32'(bif.state), 32'(RAMP));
    tick();
    bif.vld = 1'b0;
    chk("b_ss_sat", 32'(bif.ss_tmr),   32'd255);
    chk("b_run",    32'(bif.state),    32'(RUN));
    chk("b_en",     32'(bif.en_steer), 32'd1);

    // SS_STEP=1 full ramp
    aif.pwr_req = 1'b1; aif.rider_on = 1'b1; aif.steer_ok = 1'b1;
    tick();
    chk("a_ramp_state", 32'(aif.state), 32'(RAMP));
    run_vld_a(254);
    chk("a_ss_254",    32'(aif.ss_tmr),   32'd254);
    chk("a_state_254", 32'(aif.state),    32'(RAMP));
    chk("a_en_254",    32'(aif.en_steer), 32'd0);
    run_vld_a(1);
    chk("a_ss_255",  32'(aif.ss_tmr),   32'd255);
    chk("a_run",     32'(aif.state),    32'(RUN));
    chk("a_en_run",  32'(aif.en_steer), 32'd1);
    aif.steer_ok = 1'b0;
    tick();
    chk("a_en_follow0", 32'(aif.en_steer), 32'd0);
    aif.steer_ok = 1'b1;
    tick();
    chk("a_en_follow1", 32'(aif.en_steer), 32'd1);

    // overspeed: 3 samples, break, then 4 samples
    aif.too_fast = 1'b1;
    run_vld_a(3);
    chk("tf3_fault", 32'(aif.fault), 32'd0);
    chk("tf3_state", 32'(aif.state), 32'(RUN));
    aif.too_fast = 1'b0;
    run_vld_a(1);
    aif.too_fast = 1'b1;
    run_vld_a(3);
    chk("tf3b_fault", 32'(aif.fault), 32'd0);
    run_vld_a(1);
    chk("tf4_fault", 32'(aif.fault),    32'd1);
    chk("tf4_en",    32'(aif.en_steer), 32'd0);
    chk("tf4_state", 32'(aif.state),    32'(FAULT));
    chk("tf4_ss",    32'(aif.ss_tmr),   32'd255);

    // clean samples
    aif.too_fast = 1'b0;
    run_vld_a(15);
    chk("clr15_fault", 32'(aif.fault), 32'd1);
    run_vld_a(1);
`ifdef SEQ_FAULT_STICKY_EN
    chk("clr16_state", 32'(aif.state), 32'(FAULT));
    chk("clr16_fault", 32'(aif.fault), 32'd1);
`else
    chk("clr16_state", 32'(aif.state),    32'(RUN));
    chk("clr16_fault", 32'(aif.fault),    32'd0);
    chk("clr16_en",    32'(aif.en_steer), 32'd1);
`endif

    // rider steps off: ramp down
    aif.rider_on = 1'b0;
    tick();
    chk("down_state", 32'(aif.state),    32'(DOWN));
    chk("down_en",    32'(aif.en_steer), 32'd0);
    chk("down_fault", 32'(aif.fault),    32'd0);
    chk("down_pwr",   32'(aif.pwr_up),   32'd1);
    chk("down_ss",    32'(aif.ss_tmr),   32'd255);
    run_vld_a(127);
    chk("down_ss128", 32'(aif.ss_tmr), 32'd128);
    aif.rider_on = 1'b1;
    tick();
    chk("reramp_state", 32'(aif.state),  32'(RAMP));
    chk("reramp_ss",    32'(aif.ss_tmr), 32'd128);
    run_vld_a(1);
    chk("reramp_ss129", 32'(aif.ss_tmr), 32'd129);
    aif.rider_on = 1'b0;
    tick();
    chk("down2_state", 32'(aif.state), 32'(DOWN));
    run_vld_a(128);
    chk("down2_ss1",    32'(aif.ss_tmr), 32'd1);
    chk("down2_state1", 32'(aif.state),  32'(DOWN));
    run_vld_a(1);
    chk("off_ss",    32'(aif.ss_tmr), 32'd0);
    chk("off_state", 32'(aif.state),  32'(OFF));
    chk("off_pwr",   32'(aif.pwr_up), 32'd0);

    // async reset mid-ramp
    aif.rider_on = 1'b1;
    tick();
    run_vld_a(77);
    chk("mid_ss77", 32'(aif.ss_tmr), 32'd77);
    chk("mid_pwr",  32'(aif.pwr_up), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ss",    32'(aif.ss_tmr),   32'd0);
    chk("arst_pwr",   32'(aif.pwr_up),   32'd0);
    chk("arst_en",    32'(aif.en_steer), 32'd0);
    chk("arst_fault", 32'(aif.fault),    32'd0);
    chk("arst_state", 32'(aif.state),    32'(OFF));
    chk("arst_b_en",  32'(bif.en_steer), 32'd0);
    tick();
    rst_n = 1'b1;

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
